jtgng_objdma: RTL
=================

JTGNG_OBJDMA -- requirements
Module: jtgng_objdma

Interface
REQ-001 Parameter OBJMAX, default 9'h17F: last object RAM byte address copied (96 objects x 4 bytes).
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cen6  input  1  6 MHz clock enable; every state, counter and output update happens only on clk edges with cen6=1.
REQ-005 LVBL  input  1  vertical blanking when 0.
REQ-006 bus_ack  input  1  CPU bus granted (BA and BS both high).
REQ-007 ram_dout  input  8  main CPU RAM read data, synchronous, valid one cen6 tick after the address.
REQ-008 bus_req  output  1  CPU halt request.
REQ-009 blcnten  output  1  RAM address mux select: object DMA owns the RAM.
REQ-010 obj_AB  output  9  object RAM read address; RAM is at {4'hf, obj_AB}.
REQ-011 buf_we  output  1  object buffer write strobe.
REQ-012 buf_addr  output  9  object buffer write address.
REQ-013 buf_din  output  8  object buffer write data.
REQ-014 dma_done  output  1  one-cen6-tick pulse at copy completion.

Function
REQ-015 The block SHALL register LVBL on each cen6 tick into last_LVBL and detect start-of-blank as last_LVBL=1 and LVBL=0.
REQ-016 The block SHALL implement states IDLE, REQ, COPY and FLUSH; the state SHALL change only on cen6 ticks.
REQ-017 IDLE: bus_req=0, blcnten=0; on start-of-blank -> REQ with bus_req=1 from the same tick.
REQ-018 REQ: bus_req=1; when bus_ack=1 -> COPY with blcnten=1 and obj_AB=0; no timeout, REQ is held indefinitely.
REQ-019 COPY: bus_req=1 and blcnten=1; obj_AB SHALL increment by 1 per cen6 tick; on the tick where obj_AB=OBJMAX -> FLUSH.
REQ-020 The write pipeline SHALL lag the address by exactly one cen6 tick: buf_we=1, buf_addr=previous obj_AB, buf_din=ram_dout, for each address 0..OBJMAX, with no gaps.
REQ-021 FLUSH SHALL last one cen6 tick and perform the write for address OBJMAX, then -> IDLE with bus_req=0, blcnten=0, buf_we=0 and dma_done=1 for that tick.
REQ-022 A copy SHALL perform exactly OBJMAX+1 buffer writes, each address once, in ascending order.
REQ-023 Start-of-blank edges outside IDLE SHALL be ignored, with no re-trigger or queueing.
REQ-024 LVBL rising during REQ, COPY or FLUSH SHALL NOT abort the copy; it SHALL complete.
REQ-025 bus_ack dropping during COPY SHALL NOT stall or abort the copy, because the CPU is halted by bus_req and blcnten already blocks CPU RAM writes.
REQ-026 obj_AB SHALL hold its last value in IDLE and SHALL be 9 bits wide with no wrap within a copy.
REQ-027 buf_we SHALL be 0 in IDLE and REQ; buf_addr and buf_din SHALL hold their last values when buf_we=0.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, bus_req=0, blcnten=0, obj_AB=0, buf_we=0, buf_addr=0, buf_din=0, dma_done=0 and last_LVBL=1.
REQ-029 Reset asserted mid-copy SHALL abandon the copy, release the bus at once, and not resume after rst_n rises; the next copy requires a fresh start-of-blank.
REQ-030 After reset release, an LVBL already at 0 SHALL NOT start a copy until a 1->0 transition is seen.

Verification
REQ-031 LVBL 1->0 with bus_ack tied high -> bus_req=1 next tick; blcnten=1 one tick later; 384 buf_we pulses at addresses 0..0x17F; dma_done one tick; bus_req=0 after.
REQ-032 RAM model returning data=addr[7:0]^8'h5A -> buf_din at buf_addr N equals N[7:0]^8'h5A for all N; no write occurs before blcnten=1.
REQ-033 bus_ack held low for 50 ticks after the request -> bus_req stays 1, blcnten=0, no writes; copy starts the tick after bus_ack rises.
REQ-034 Second LVBL falling edge and LVBL rising mid-COPY -> copy completes with exactly 384 writes and a single dma_done.
REQ-035 rst_n pulsed low at obj_AB=0x80 -> all outputs 0 asynchronously; no activity until the next LVBL 1->0.
REQ-036 cen6 asserted every 4th clk -> all transitions occur only on cen6 ticks; write count and data unchanged.

Source files
------------

// File: rtl/jtgng_objdma_if.sv
// Object DMA port bundle: timing/enable inputs and RAM read data in, halt request and buffer write port out.
// master = DMA engine side, slave = CPU/RAM/buffer side.
interface jtgng_objdma_if;
    logic       cen6;
    logic       LVBL;
    logic       bus_ack;
    logic [7:0] ram_dout;
    logic       bus_req;
    logic       blcnten;
    logic [8:0] obj_AB;
    logic       buf_we;
    logic [8:0] buf_addr;
    logic [7:0] buf_din;
    logic       dma_done;

    modport master (
        input  cen6, LVBL, bus_ack, ram_dout,
        output bus_req, blcnten, obj_AB, buf_we, buf_addr, buf_din, dma_done
    );

    modport slave (
        output cen6, LVBL, bus_ack, ram_dout,
        input  bus_req, blcnten, obj_AB, buf_we, buf_addr, buf_din, dma_done
    );
endinterface

// File: rtl/jtgng_objdma.sv
// Copies OBJMAX+1 object RAM bytes into the sprite buffer each vertical blank; bus_req rises one cen6 tick after the LVBL fall.
// Waits in REQ for bus_ack with no timeout; each buffer write trails its read address by one tick, final write in FLUSH.
module jtgng_objdma #(
    parameter logic [8:0] OBJMAX = 9'h17F
) (
    input  logic           clk,
    input  logic           rst_n,
    jtgng_objdma_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, COPY, FLUSH} state_t;

    state_t     state, state_nx;
    logic       last_lvbl;
    logic       armed, armed_nx;
    logic       start;
    logic       bus_req_q, bus_req_nx;
    logic       blcnten_q, blcnten_nx;
    logic [8:0] obj_ab_q, obj_ab_nx;
    logic       buf_we_q, buf_we_nx;
    logic [8:0] buf_addr_q, buf_addr_nx;
    logic [7:0] buf_din_q, buf_din_nx;
    logic       dma_done_q, dma_done_nx;

    // last_lvbl resets high, so armed blocks a copy until LVBL has been seen high once after reset
    assign start = armed & last_lvbl & ~bus.LVBL;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_lvbl  <= 1'b1;
            armed      <= 1'b0;
            bus_req_q  <= 1'b0;
            blcnten_q  <= 1'b0;
            obj_ab_q   <= '0;
            buf_we_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_din_q  <= '0;
            dma_done_q <= 1'b0;
        end else if (bus.cen6) begin
            state      <= state_nx;
            last_lvbl  <= bus.LVBL;
            armed      <= armed_nx;
            bus_req_q  <= bus_req_nx;
            blcnten_q  <= blcnten_nx;
            obj_ab_q   <= obj_ab_nx;
            buf_we_q   <= buf_we_nx;
            buf_addr_q <= buf_addr_nx;
            buf_din_q  <= buf_din_nx;
            dma_done_q <= dma_done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        armed_nx    = armed | bus.LVBL;
        bus_req_nx  = bus_req_q;
        blcnten_nx  = blcnten_q;
        obj_ab_nx   = obj_ab_q;
        buf_we_nx   = 1'b0;
        buf_addr_nx = buf_addr_q;
        buf_din_nx  = buf_din_q;
        dma_done_nx = 1'b0;

        case (state)
            IDLE: begin
                bus_req_nx = 1'b0;
                blcnten_nx = 1'b0;
                if (start) begin
                    state_nx   = REQ;
                    bus_req_nx = 1'b1;
                end
            end
            REQ: begin
                bus_req_nx = 1'b1;
                if (bus.bus_ack) begin
                    state_nx   = COPY;
                    blcnten_nx = 1'b1;
                    obj_ab_nx  = '0;
                end
            end
            COPY: begin
                bus_req_nx = 1'b1;
                blcnten_nx = 1'b1;
                // ram_dout now holds the byte for the previous address; the first COPY tick has none yet
                if (obj_ab_q != '0) begin
                    buf_we_nx   = 1'b1;
                    buf_addr_nx = obj_ab_q - 9'd1;
                    buf_din_nx  = bus.ram_dout;
                end
                if (obj_ab_q == OBJMAX) begin
                    state_nx = FLUSH;
                end else begin
                    obj_ab_nx = obj_ab_q + 9'd1;
                end
            end
            FLUSH: begin
                state_nx    = IDLE;
                bus_req_nx  = 1'b0;
                blcnten_nx  = 1'b0;
                buf_we_nx   = 1'b1;
                buf_addr_nx = OBJMAX;
                buf_din_nx  = bus.ram_dout;
                dma_done_nx = 1'b1;
            end
            default: begin
                state_nx   = IDLE;
                bus_req_nx = 1'b0;
                blcnten_nx = 1'b0;
            end
        endcase
    end

    assign bus.bus_req  = bus_req_q;
    assign bus.blcnten  = blcnten_q;
    assign bus.obj_AB   = obj_ab_q;
    assign bus.buf_we   = buf_we_q;
    assign bus.buf_addr = buf_addr_q;
    assign bus.buf_din  = buf_din_q;
    assign bus.dma_done = dma_done_q;
endmodule
